// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: glyph table,
// blank pattern and segment bit positions.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high a..g patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic logic [6:0] glyph_of(input logic [3:0] digit);
        return GLYPH[digit];
    endfunction

endpackage

// File: rtl/seg_scan_decode.sv
// Combinational hex-to-segment decoder producing an active-high pattern,
// with the a..g field optionally blanked and the dp bit passed through.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    always_comb begin
        pattern                = SEG_BLANK;
        pattern[SEG_G:SEG_A]   = blank ? 7'h00 : glyph_of(digit);
        pattern[SEG_DP]        = dp;
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment driver: prescaled digit scan, frame-synchronous
// shadow register, leading-zero blanking, PWM brightness and ghost blanking.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SEL_W          = 3,
    parameter int SEL_BASE       = 4,
    parameter int DIV            = 50000,
    parameter int GUARD          = 1,
    parameter int PWM_W          = 3,
    parameter int ACTIVE_LOW_SEG = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic [PWM_W-1:0]        bright,
    output logic [SEL_W-1:0]        sel,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);
    localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(SEL_BASE);
    localparam logic [7:0]       SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? ~SEG_BLANK : SEG_BLANK;

    function automatic logic [7:0] to_pins(input logic [7:0] pattern);
        return (ACTIVE_LOW_SEG != 0) ? ~pattern : pattern;
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [PWM_W-1:0]        pwm;
    logic [PWM_W-1:0]        pwm_nxt;
    logic                    run;
    logic                    slot_end;
    logic                    boundary;

    logic                    pending;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [4*NUM_DIGITS-1:0] shadow_val_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_dp_nxt;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              digit_cur;
    logic                    dp_cur;
    logic                    blank_cur;
    logic [7:0]              pattern;
    logic                    lit;
    logic                    guard;
    logic [7:0]              seg_nxt;

    // Scan counters. The first enabled edge after idle or reset (run low)
    // parks everything at slot 0 and is treated as a frame boundary.
    always_comb begin
        slot_end = (cnt == CNT_LAST);
        boundary = en && (!run || (slot_end && (idx == IDX_LAST)));
        cnt_nxt  = '0;
        idx_nxt  = '0;
        pwm_nxt  = '0;
        if (en && run) begin
            cnt_nxt = slot_end ? '0 : cnt + CNT_W'(1);
            idx_nxt = idx;
            if (slot_end) begin
                idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            pwm_nxt = pwm + PWM_W'(1);
        end
    end

    // A load coinciding with the boundary bypasses the pending register.
    always_comb begin
        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
        if (boundary) begin
            if (load) begin
                shadow_val_nxt = val;
                shadow_dp_nxt  = dp;
            end else if (pending) begin
                shadow_val_nxt = pend_val;
                shadow_dp_nxt  = pend_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pwm        <= '0;
            run        <= 1'b0;
            pending    <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            pwm        <= pwm_nxt;
            run        <= en;
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Pending data is qualified by the pending flag, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load && !boundary) begin
            pend_val <= val;
            pend_dp  <= dp;
        end
    end

    // Digit i is a leading zero when it and every more significant digit is zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (shadow_val_nxt[4*i +: 4] == 4'h0);
            lz_mask[i] = blank_lz && zero_above;
        end
    end

    always_comb begin
        digit_cur = 4'h0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                digit_cur = shadow_val_nxt[4*i +: 4];
                dp_cur    = shadow_dp_nxt[i];
                blank_cur = lz_mask[i];
            end
        end
    end

    seg_decode u_decode (
        .digit   (digit_cur),
        .dp      (dp_cur),
        .blank   (blank_cur),
        .pattern (pattern)
    );

    // Pins are computed from next-state values so sel, seg and frame_tick
    // all reflect the same slot and cycle as the counters.
    always_comb begin
        lit     = (bright == '1) || (pwm_nxt < bright);
        guard   = (cnt_nxt < GUARD_END);
        seg_nxt = (en && lit && !guard) ? to_pins(pattern) : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= SEL_FIRST;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            sel        <= SEL_FIRST + SEL_W'(idx_nxt);
            seg        <= seg_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (fast active-high, slower active-low)
// compared every cycle against a time-based model plus directed literals.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [11:0] val;
    logic [2:0]  dp;
    logic        blank_lz;
    logic [2:0]  bright;
    logic [2:0]  sel_a, sel_b;
    logic [7:0]  seg_a, seg_b;
    logic        ft_a, ft_b;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    seg_scan #(.NUM_DIGITS(3), .SEL_W(3), .SEL_BASE(4), .DIV(4), .GUARD(1),
               .PWM_W(3), .ACTIVE_LOW_SEG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .val(val), .dp(dp),
        .blank_lz(blank_lz), .bright(bright), .sel(sel_a), .seg(seg_a),
        .frame_tick(ft_a));

    seg_scan #(.NUM_DIGITS(3), .SEL_W(3), .SEL_BASE(4), .DIV(16), .GUARD(0),
               .PWM_W(3), .ACTIVE_LOW_SEG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .val(val), .dp(dp),
        .blank_lz(blank_lz), .bright(bright), .sel(sel_b), .seg(seg_b),
        .frame_tick(ft_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int div_of(input int k);   return (k == 0) ? 4 : 16; endfunction
    function automatic int guard_of(input int k); return (k == 0) ? 1 : 0;  endfunction
    function automatic bit low_of(input int k);   return (k == 1);          endfunction

    // Model: t counts enabled cycles since the frame-starting edge; slot,
    // prescaler phase and PWM phase all follow from t arithmetically.
    int          t [2];
    bit          running [2];
    logic [11:0] sh_v [2];
    logic [2:0]  sh_d [2];
    logic [11:0] pd_v [2];
    logic [2:0]  pd_d [2];
    bit          pd [2];
    logic [2:0]  e_sel [2];
    logic [7:0]  e_seg [2];
    logic        e_ft [2];
    bit          bnd;
    int          slot, ph_cnt, ph_pwm;
    logic [3:0]  dig;
    bit          lz_m, lit_m;
    logic [7:0]  raw;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                running[k] = 0; t[k] = 0; sh_v[k] = '0; sh_d[k] = '0; pd[k] = 0;
                e_sel[k] = 3'd4; e_seg[k] = low_of(k) ? 8'hFF : 8'h00; e_ft[k] = 1'b0;
            end else begin
                if (en) begin
                    if (running[k]) t[k] = t[k] + 1;
                    else begin running[k] = 1; t[k] = 0; end
                    bnd = (t[k] % (div_of(k) * 3)) == 0;
                end else begin
                    running[k] = 0; t[k] = 0; bnd = 0;
                end
                if (bnd) begin
                    if (load) begin sh_v[k] = val; sh_d[k] = dp; end
                    else if (pd[k]) begin sh_v[k] = pd_v[k]; sh_d[k] = pd_d[k]; end
                    pd[k] = 0;
                end else if (load) begin
                    pd_v[k] = val; pd_d[k] = dp; pd[k] = 1;
                end
                if (!en) begin
                    e_sel[k] = 3'd4; e_seg[k] = low_of(k) ? 8'hFF : 8'h00; e_ft[k] = 1'b0;
                end else begin
                    slot   = (t[k] / div_of(k)) % 3;
                    ph_cnt = t[k] % div_of(k);
                    ph_pwm = t[k] % 8;
                    dig    = 4'(sh_v[k] >> (4 * slot));
                    lz_m   = blank_lz && (slot > 0) && ((sh_v[k] >> (4 * slot)) == 12'h0);
                    lit_m  = (bright == 3'd7) || (ph_pwm < int'(bright));
                    raw    = (lit_m && ph_cnt >= guard_of(k)) ?
                             {sh_d[k][slot], lz_m ? 7'h00 : glyph(dig)} : 8'h00;
                    e_seg[k] = low_of(k) ? ~raw : raw;
                    e_sel[k] = 3'(4 + slot);
                    e_ft[k]  = bnd;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_sel_a", 32'(sel_a), 32'(e_sel[0]));
        chk("mdl_seg_a", 32'(seg_a), 32'(e_seg[0]));
        chk("mdl_ft_a",  32'(ft_a),  32'(e_ft[0]));
        chk("mdl_sel_b", 32'(sel_b), 32'(e_sel[1]));
        chk("mdl_seg_b", 32'(seg_b), 32'(e_seg[1]));
        chk("mdl_ft_b",  32'(ft_b),  32'(e_ft[1]));
    end

    task automatic wait_ft(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((k == 0) ? ft_a : ft_b) !== 1'b1) && n < 200);
        chk((k == 0) ? "ft_wait_a" : "ft_wait_b", 32'((k == 0) ? ft_a : ft_b), 32'd1);
    endtask

    task automatic load_word(input logic [11:0] v, input logic [2:0] d);
        @(negedge clk);
        load = 1'b1; val = v; dp = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Checks one full frame of instance A: 1 guard cycle + 3 lit cycles per slot.
    task automatic frame_check(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2);
        logic [7:0] want;
        wait_ft(0);
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            case (j / 4)
                0:       want = e0;
                1:       want = e1;
                default: want = e2;
            endcase
            if (j % 4 == 0) want = 8'h00;
            chk({nm, "_sel"}, 32'(sel_a), 32'(4 + j / 4));
            chk({nm, "_seg"}, 32'(seg_a), 32'(want));
            chk({nm, "_ft"},  32'(ft_a),  32'(j == 0));
        end
    endtask

    task automatic idle_check(input string nm);
        chk({nm, "_sel_a"}, 32'(sel_a), 32'd4);
        chk({nm, "_seg_a"}, 32'(seg_a), 32'h00);
        chk({nm, "_ft_a"},  32'(ft_a),  32'd0);
        chk({nm, "_sel_b"}, 32'(sel_b), 32'd4);
        chk({nm, "_seg_b"}, 32'(seg_b), 32'hFF);
        chk({nm, "_ft_b"},  32'(ft_b),  32'd0);
    endtask

    initial begin
        int lit_n;
        rst_n = 1'b1; en = 1'b0; load = 1'b0; val = '0; dp = '0;
        blank_lz = 1'b0; bright = 3'd7;
        #1 rst_n = 1'b0;
        #3 idle_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load while disabled, then enable: the first edge starts a frame.
        load_word(12'h3A5, 3'b000);
        repeat (2) @(negedge clk);
        idle_check("en_off");
        @(negedge clk);
        en = 1'b1;
        frame_check("scan", 8'h6D, 8'h77, 8'h4F);
        @(negedge clk);
        chk("ft_period", 32'(ft_a), 32'd1);

        // Two loads mid-frame: current frame keeps 3A5, next shows the latest.
        load_word(12'h111, 3'b000);
        load_word(12'h222, 3'b000);
        repeat (5) @(negedge clk);
        chk("hold_sel", 32'(sel_a), 32'd6);
        chk("hold_seg", 32'(seg_a), 32'h4F);
        frame_check("latest", 8'h5B, 8'h5B, 8'h5B);

        // Load high on the boundary edge itself is shown in that frame.
        load = 1'b1; val = 12'h777; dp = 3'b000;
        frame_check("bnd", 8'h07, 8'h07, 8'h07);
        load = 1'b0;

        blank_lz = 1'b1;
        load_word(12'h005, 3'b100);
        frame_check("lz", 8'h6D, 8'h00, 8'h80);
        load_word(12'h000, 3'b000);
        frame_check("lz0", 8'h3F, 8'h00, 8'h00);

        blank_lz = 1'b0;
        bright = 3'd0;
        load_word(12'h3A5, 3'b000);
        frame_check("dark", 8'h00, 8'h00, 8'h00);

        bright = 3'd2;
        lit_n = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (seg_b !== 8'hFF) lit_n++;
        end
        chk("pwm_lit_b", 32'(lit_n), 32'd12);

        bright = 3'd7;
        load_word(12'h888, 3'b111);
        wait_ft(1);
        chk("pol_sel_b", 32'(sel_b), 32'd4);
        chk("pol_seg_b", 32'(seg_b), 32'h00);

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        idle_check("en_low");
        load_word(12'h123, 3'b000);
        @(negedge clk);
        en = 1'b1;
        frame_check("en_rise", 8'h4F, 8'h5B, 8'h06);

        // Reset mid-slot discards pending data; next frame shows zeros.
        load_word(12'h0F0, 3'b000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 idle_check("rst_mid");
        #1 rst_n = 1'b1;
        frame_check("post_rst", 8'h3F, 8'h3F, 8'h3F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised multiplexed seven-segment display driver. It time-multiplexes NUM_DIGITS hex digits onto one shared segment bus and a binary digit-select bus for the board's select decoder. Beyond a plain scanner, it adds a programmable scan rate, a frame-synchronous shadow register for tear-free updates, decimal points, leading-zero blanking, PWM brightness, inter-digit ghost blanking and segment polarity selection. It sits between the CPU's display register and the board pins.

## Interface
- NUM_DIGITS, 3: digits scanned; legal range 1..8.
- SEL_W, 3: width of `sel`.
- SEL_BASE, 4: `sel` code for digit 0. SEL_BASE+NUM_DIGITS-1 must fit in SEL_W.
- DIV, 50000: clocks per digit slot. Must satisfy DIV >= GUARD+2.
- GUARD, 1: blank cycles at the start of each slot.
- PWM_W, 3: width of the brightness control.
- ACTIVE_LOW_SEG, 0: 1 inverts all of `seg`, dp included.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- load  in  1  capture `val` and `dp` into the pending register.
- val  in  4*NUM_DIGITS  hex digits; digit i is val[4i+3:4i], digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  enable leading-zero blanking.
- bright  in  PWM_W  brightness; 0 = dark, all-ones = full.
- sel  out  SEL_W  digit select, registered.
- seg  out  8  segments; bit0..6 = a..g, bit7 = dp; registered.
- frame_tick  out  1  one-cycle pulse at each frame start.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps.
- Slot advance: on the edge where cnt==DIV-1, digit index `idx` increments; after NUM_DIGITS-1 it wraps to 0.
- `sel` = SEL_BASE + idx.
- Load path:
  - `load` copies val/dp into a pending register and sets a pending flag. The latest load wins.
  - Frame boundary: the edge where idx wraps to 0. At that edge, if pending is set, the shadow register takes the pending value and pending clears.
  - If `load` is high on the boundary edge itself, that cycle's val/dp go directly to shadow.
  - The display reads only from shadow.
- Glyphs (active-high): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Leading-zero blanking: when blank_lz=1, digit i>0 blanks its a–g bits if shadow digits NUM_DIGITS-1 down to i are all zero. Digit 0 is never blanked. The dp bit is unaffected.
- PWM: free-running PWM_W-bit counter `pwm` increments every clk. A segment is lit when bright==all-ones or pwm < bright.
- Guard: seg is forced blank while cnt < GUARD.
- Output composition: seg = polarity(lit && !guard ? {dp_i, glyph_i masked by lz} : 8'h00).
- en=0: cnt, idx and pwm are held at 0. sel=SEL_BASE, seg=blank, frame_tick=0. Load capture still works. When en rises, the first edge starts a frame and the boundary transfer applies.

## Timing
- Reset values, applied asynchronously: cnt=0, idx=0, pwm=0, pending=0, shadow=0, sel=SEL_BASE, seg=blank (00, or FF when ACTIVE_LOW_SEG=1), frame_tick=0.
- Output alignment: sel and seg change on the same edge, so seg always matches the current sel. Latency from cnt/idx/pwm state to pins is one register stage.
- frame_tick is high for exactly the one cycle following the wrap edge, coincident with sel=SEL_BASE.
- Update latency: a load becomes visible at the next frame boundary. Worst case is DIV*NUM_DIGITS cycles.
- Reset asserted mid-frame discards pending data. The first frame after release shows zeros.

## Structure
- Package `seg_pkg`:
  - 16-entry glyph constant array.
  - SEG_BLANK constant.
  - Segment bit-index constants.
- Sub-module `seg_decode`: combinational; inputs 4-bit digit, dp, blank; output 8-bit active-high pattern.
- Top level holds counters, pending/shadow registers, LZ mask, PWM/guard gating, polarity and output registers.

## Test plan
- Reset: pulse rst_n low mid-slot with NUM_DIGITS=3 → sel=4, seg=00 and frame_tick=0 asynchronously, before the next edge.
- Scan: DIV=4, GUARD=1, bright=7, load 12'h3A5, wait one boundary → sel 4/5/6 show seg 6D/77/4F. Each slot is 1 blank cycle then 3 lit cycles. frame_tick repeats every 12 cycles.
- Load timing: load 12'h111 mid-frame, then 12'h222 before the boundary → the current frame is unchanged and the next frame shows 5B on all digits. A load on the boundary edge is shown in that same frame.
- Leading zero: blank_lz=1, val=12'h005, dp=3'b100 → digit0 6D, digit1 00, digit2 80. val=0 → digit0 3F only.
- Brightness: bright=0 → seg stays 00. bright=2, PWM_W=3, DIV=16, GUARD=0 → glyph lit on exactly 2 of every 8 cycles.
- Polarity/enable: ACTIVE_LOW_SEG=1 → reset seg=FF; digit 8 with dp → 00. en=0 → sel=4 and seg=FF held.
